// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a 4-digit 7-segment display
// (MM:SS). Each scan slot shows one blank cycle and then the selected digit.
// Digits are captured into a snapshot once per frame so that a frame never
// mixes two time values. Segments and anodes are active-low and registered.
module seg_scan_driver (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_tick,
  input  logic       blink_tick,
  input  logic       adj,
  input  logic       sel,
  input  logic [3:0] d0,
  input  logic [2:0] d1,
  input  logic [3:0] d2,
  input  logic [2:0] d3,
  output logic [7:0] seg,
  output logic [3:0] an
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] GLYPH_DASH = 7'b0111111;

  // Decode one digit to active-low {g,f,e,d,c,b,a}. Values above max_val
  // cannot occur on a clock display and are shown as a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] val, input logic [3:0] max_val);
    logic [6:0] g;
    g = GLYPH_DASH;
    if (val <= max_val) begin
      case (val)
        4'd0:    g = 7'b1000000;
        4'd1:    g = 7'b1111001;
        4'd2:    g = 7'b0100100;
        4'd3:    g = 7'b0110000;
        4'd4:    g = 7'b0011001;
        4'd5:    g = 7'b0010010;
        4'd6:    g = 7'b0000010;
        4'd7:    g = 7'b1111000;
        4'd8:    g = 7'b0000000;
        4'd9:    g = 7'b0010000;
        default: g = GLYPH_DASH;
      endcase
    end
    return g;
  endfunction

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_idx;
  logic [1:0] w_idx_next;
  logic       r_blink_phase;
  logic       w_blink_phase_next;
  logic [3:0] r_snap [4];
  logic       w_capture;
  logic [3:0] r_an;
  logic [3:0] w_an_next;
  logic [7:0] r_seg;
  logic [7:0] w_seg_next;
  logic [6:0] w_glyph [4];
  logic [3:0] w_digit_in [4];
  logic       w_blank_pos;
  logic       w_dp;

  // Tens inputs are 3 bits wide; widen them so every position shares one format.
  assign w_digit_in[0] = d0;
  assign w_digit_in[1] = {1'b0, d1};
  assign w_digit_in[2] = d2;
  assign w_digit_in[3] = {1'b0, d3};

  // Per-position decoders: odd positions are tens (0-5), even are ones (0-9).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      localparam logic [3:0] MAX_VAL = ((gi % 2) == 1) ? 4'd5 : 4'd9;
      assign w_glyph[gi] = f_decode(r_snap[gi], MAX_VAL);
    end
  endgenerate

  // The position under the scan index is hidden while blinking its pair.
  assign w_blank_pos = adj & r_blink_phase & (r_idx[1] == sel);
  // Decimal point separates minutes from seconds, lit at position 2 only.
  assign w_dp        = (r_idx != 2'd2);

  // Sequencer next-state and output-register next values.
  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_idx;
    w_an_next          = r_an;
    w_seg_next         = r_seg;
    w_capture          = 1'b0;
    w_blink_phase_next = r_blink_phase ^ blink_tick;
    if (scan_tick) begin
      w_idx_next   = r_idx + 2'd1;
      w_capture    = (r_idx == 2'd3);
      w_state_next = ST_BLANK;
      w_an_next    = 4'b1111;
    end else if (r_state == ST_BLANK) begin
      w_state_next = ST_DRIVE;
      w_an_next    = w_blank_pos ? 4'b1111 : ~(4'b0001 << r_idx);
      w_seg_next   = {w_dp, w_glyph[r_idx]};
    end
  end

  // State, index, blink phase and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_BLANK;
      r_idx         <= 2'd3;
      r_blink_phase <= 1'b0;
      r_an          <= 4'b1111;
      r_seg         <= 8'hFF;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_blink_phase <= w_blink_phase_next;
      r_an          <= w_an_next;
      r_seg         <= w_seg_next;
    end
  end

  // Frame snapshot, refreshed as the index wraps back to position 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_snap[i] <= 4'd0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < 4; i++) begin
        r_snap[i] <= w_digit_in[i];
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: directed literal checks plus a
// randomized run compared every cycle against a behavioural display model.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_tick = 1'b0;
  logic       blink_tick = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] d0 = 4'd0;
  logic [2:0] d1 = 3'd0;
  logic [3:0] d2 = 4'd0;
  logic [2:0] d3 = 3'd0;
  logic [7:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  seg_scan_driver dut (
    .clk        (clk),
    .rst        (rst),
    .scan_tick  (scan_tick),
    .blink_tick (blink_tick),
    .adj        (adj),
    .sel        (sel),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         m_idx;
  int         m_snap [4];
  bit         m_phase;
  bit         m_pending;
  logic [3:0] m_an;
  logic [7:0] m_seg;
  bit         m_valid = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_idx     = 3;
        for (int i = 0; i < 4; i++) m_snap[i] = 0;
        m_phase   = 1'b0;
        m_pending = 1'b1;
        m_an      = 4'hF;
        m_seg     = 8'hFF;
        m_valid   = 1'b1;
      end else begin
        if (scan_tick) begin
          if (m_idx == 3) begin
            m_snap[0] = int'(d0);
            m_snap[1] = int'(d1);
            m_snap[2] = int'(d2);
            m_snap[3] = int'(d3);
          end
          m_idx     = (m_idx + 1) % 4;
          m_pending = 1'b1;
          m_an      = 4'hF;
        end else if (m_pending) begin
          int  lim;
          int  v;
          bit  hide;
          logic [6:0] g;
          m_pending = 1'b0;
          hide = adj && m_phase && ((m_idx >= 2) == sel);
          m_an = hide ? 4'hF : 4'(15 - (1 << m_idx));
          lim  = (m_idx % 2 == 1) ? 6 : 10;
          v    = m_snap[m_idx];
          g    = (v < lim) ? glyph_tab[v] : 7'h3F;
          m_seg = {(m_idx != 2), g};
        end
        if (blink_tick) m_phase = !m_phase;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        checks = checks + 1;
        if (an !== m_an || seg !== m_seg) begin
          errors = errors + 1;
          $display("FAIL model_cmp t=%0t: got an=%b seg=%b expected an=%b seg=%b",
                   $time, an, seg, m_an, m_seg);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One scan slot: tick, blank cycle, driven digit, then idle to 8 clocks total.
  task automatic slot(input string name, input logic [3:0] exp_an, input logic [7:0] exp_seg);
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    chk({name, "_blank_an"}, {4'h0, an}, {4'h0, 4'hF});
    step();
    chk({name, "_an"}, {4'h0, an}, {4'h0, exp_an});
    chk({name, "_seg"}, seg, exp_seg);
    $display("slot %s: an=%b seg=%b", name, an, seg);
    repeat (6) step();
  endtask

  initial begin
    #1 rst = 1'b1;
    step();
    step();
    chk("reset_an", {4'h0, an}, 8'h0F);
    chk("reset_seg", seg, 8'hFF);
    rst = 1'b0;
    step();

    d3 = 3'd1; d2 = 4'd2; d1 = 3'd3; d0 = 4'd4;
    slot("p0_d4", 4'b1110, 8'b10011001);
    slot("p1_d3", 4'b1101, 8'b10110000);
    d0 = 4'd9;
    slot("p2_d2", 4'b1011, 8'b00100100);
    slot("p3_d1", 4'b0111, 8'b11111001);
    slot("p0_d9", 4'b1110, 8'b10010000);

    adj = 1'b1; sel = 1'b1;
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    slot("blink_p1", 4'b1101, 8'b10110000);
    slot("blink_p2", 4'b1111, 8'b00100100);
    slot("blink_p3", 4'b1111, 8'b11111001);
    slot("blink_p0", 4'b1110, 8'b10010000);
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    slot("unblink_p1", 4'b1101, 8'b10110000);
    slot("unblink_p2", 4'b1011, 8'b00100100);
    slot("unblink_p3", 4'b0111, 8'b11111001);

    adj = 1'b0;
    d1 = 3'd7;
    slot("dash_p0", 4'b1110, 8'b10010000);
    slot("dash_p1", 4'b1101, 8'b10111111);

    // Asynchronous reset in the middle of a driven slot.
    #1 rst = 1'b1;
    #1;
    chk("async_rst_an", {4'h0, an}, 8'h0F);
    chk("async_rst_seg", seg, 8'hFF);
    step();
    step();
    rst = 1'b0;
    step();

    // Back-to-back scan ticks stay blank; index advances on each tick.
    scan_tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("burst_an", {4'h0, an}, 8'h0F);
    end
    scan_tick = 1'b0;
    step();
    step();
    chk("burst_end_an", {4'h0, an}, {4'h0, 4'b1011});
    chk("burst_end_seg", seg, 8'b00100100);

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      scan_tick  = ($urandom_range(0, 3) == 0);
      blink_tick = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 15) == 0) adj = 1'($urandom);
      if ($urandom_range(0, 15) == 0) sel = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        d0 = 4'($urandom_range(0, 15));
        d1 = 3'($urandom_range(0, 7));
        d2 = 4'($urandom_range(0, 15));
        d3 = 3'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    scan_tick = 1'b0;
    blink_tick = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
